// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//
// Instruction sequencer for the small RISC stored-program machine. It walks
// each instruction through fetch, decode and execute states. From the current
// state and the instruction register it combinationally drives the ALU
// opcode, the two bus multiplexer selects and every datapath/memory load
// strobe. The registered ALU zero flag resolves the BRZ conditional branch.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset (state -> IDLE, strobes 0)
//   instruction  current instruction register contents
//                (opcode [WORD-1:WORD-4], src [3:2], dest [1:0])
//   zero         registered ALU zero flag
//   alu_opcode   opcode field of instruction, passed straight to the ALU
//   load_r       one-hot load strobe for general registers R0..R3
//   load_pc      load PC from bus_2
//   inc_pc       increment PC
//   sel_bus_1    bus_1 source: 0..3 = R0..R3, 4 = PC
//   sel_bus_2    bus_2 source: 0 = ALU_out, 1 = bus_1, 2 = mem_word
//   load_ir      load instruction register
//   load_add_r   load memory address register
//   load_reg_y   load ALU operand register Y
//   load_reg_z   load the zero-flag register
//   write        memory write strobe
//   state        current state encoding, for debug/verification
// -----------------------------------------------------------------------------
module control_unit #(
    parameter int WORD = 8,
    parameter int NREG = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [WORD-1:0] instruction,
    input  logic            zero,
    output logic [3:0]      alu_opcode,
    output logic [NREG-1:0] load_r,
    output logic            load_pc,
    output logic            inc_pc,
    output logic [2:0]      sel_bus_1,
    output logic [1:0]      sel_bus_2,
    output logic            load_ir,
    output logic            load_add_r,
    output logic            load_reg_y,
    output logic            load_reg_z,
    output logic            write,
    output logic [3:0]      state
);

    localparam int RSEL = $clog2(NREG);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_FET1 = 4'd1,
        S_FET2 = 4'd2,
        S_DEC  = 4'd3,
        S_EX1  = 4'd4,
        S_RD1  = 4'd5,
        S_RD2  = 4'd6,
        S_WR1  = 4'd7,
        S_WR2  = 4'd8,
        S_BR1  = 4'd9,
        S_BR2  = 4'd10,
        S_HALT = 4'd11
    } state_t;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_NOT = 4'd4;
    localparam logic [3:0] OP_RD  = 4'd5;
    localparam logic [3:0] OP_WR  = 4'd6;
    localparam logic [3:0] OP_BR  = 4'd7;
    localparam logic [3:0] OP_BRZ = 4'd8;

    localparam logic [2:0] SEL1_PC   = 3'd4;
    localparam logic [1:0] SEL2_ALU  = 2'd0;
    localparam logic [1:0] SEL2_BUS1 = 2'd1;
    localparam logic [1:0] SEL2_MEM  = 2'd2;

    state_t            state_reg;
    state_t            state_next;
    logic              run_reg;
    logic              load_dest;
    logic [RSEL-1:0]   src;
    logic [RSEL-1:0]   dest;

    assign alu_opcode = instruction[WORD-1 -: 4];
    assign src        = instruction[2*RSEL-1:RSEL];
    assign dest       = instruction[RSEL-1:0];
    assign state      = state_reg;

    // run_reg holds the sequencer in IDLE for one full cycle after reset
    // release, so the first FET1 lands on the second rising edge and the
    // asynchronous deassertion has a whole cycle to settle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
            run_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            run_reg   <= 1'b1;
        end
    end

    // Register load strobes are decoded from a single enable and dest, so at
    // most one bit can ever be set.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_load_r
            assign load_r[gi] = load_dest && (dest == RSEL'(gi));
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        sel_bus_1  = 3'd0;
        sel_bus_2  = SEL2_ALU;
        load_dest  = 1'b0;
        load_pc    = 1'b0;
        inc_pc     = 1'b0;
        load_ir    = 1'b0;
        load_add_r = 1'b0;
        load_reg_y = 1'b0;
        load_reg_z = 1'b0;
        write      = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (run_reg) begin
                    state_next = S_FET1;
                end
            end

            S_FET1: begin
                sel_bus_1  = SEL1_PC;
                sel_bus_2  = SEL2_BUS1;
                load_add_r = 1'b1;
                state_next = S_FET2;
            end

            S_FET2: begin
                sel_bus_2  = SEL2_MEM;
                load_ir    = 1'b1;
                inc_pc     = 1'b1;
                state_next = S_DEC;
            end

            S_DEC: begin
                case (alu_opcode)
                    OP_NOP: begin
                        state_next = S_FET1;
                    end
                    OP_ADD, OP_SUB, OP_AND: begin
                        sel_bus_1  = 3'(src);
                        sel_bus_2  = SEL2_BUS1;
                        load_reg_y = 1'b1;
                        state_next = S_EX1;
                    end
                    OP_NOT: begin
                        sel_bus_1  = 3'(src);
                        sel_bus_2  = SEL2_ALU;
                        load_reg_z = 1'b1;
                        load_dest  = 1'b1;
                        state_next = S_FET1;
                    end
                    OP_RD, OP_WR, OP_BR: begin
                        sel_bus_1  = SEL1_PC;
                        sel_bus_2  = SEL2_BUS1;
                        load_add_r = 1'b1;
                        if (alu_opcode == OP_RD) begin
                            state_next = S_RD1;
                        end else if (alu_opcode == OP_WR) begin
                            state_next = S_WR1;
                        end else begin
                            state_next = S_BR1;
                        end
                    end
                    OP_BRZ: begin
                        if (zero) begin
                            sel_bus_1  = SEL1_PC;
                            sel_bus_2  = SEL2_BUS1;
                            load_add_r = 1'b1;
                            state_next = S_BR1;
                        end else begin
                            // Not taken: step the PC past the target word.
                            inc_pc     = 1'b1;
                            state_next = S_FET1;
                        end
                    end
                    default: begin
                        state_next = S_HALT;
                    end
                endcase
            end

            // The ALU sees Reg_Y (src) on data_2 and bus_1 (dest) on data_1.
            S_EX1: begin
                sel_bus_1  = 3'(dest);
                sel_bus_2  = SEL2_ALU;
                load_reg_z = 1'b1;
                load_dest  = 1'b1;
                state_next = S_FET1;
            end

            S_RD1: begin
                sel_bus_2  = SEL2_MEM;
                load_add_r = 1'b1;
                inc_pc     = 1'b1;
                state_next = S_RD2;
            end

            S_RD2: begin
                sel_bus_2  = SEL2_MEM;
                load_dest  = 1'b1;
                state_next = S_FET1;
            end

            S_WR1: begin
                sel_bus_2  = SEL2_MEM;
                load_add_r = 1'b1;
                inc_pc     = 1'b1;
                state_next = S_WR2;
            end

            S_WR2: begin
                sel_bus_1  = 3'(src);
                write      = 1'b1;
                state_next = S_FET1;
            end

            S_BR1: begin
                sel_bus_2  = SEL2_MEM;
                load_add_r = 1'b1;
                state_next = S_BR2;
            end

            S_BR2: begin
                sel_bus_2  = SEL2_MEM;
                load_pc    = 1'b1;
                state_next = S_FET1;
            end

            S_HALT: begin
                state_next = S_HALT;
            end

            default: begin
                state_next = S_HALT;
            end
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit
//
// Directed bench for control_unit. Each instruction is walked cycle by cycle
// from FET1 back to FET1; in every cycle the state, both bus selects and the
// full strobe set are compared against hand-written expected values.
// -----------------------------------------------------------------------------
module tb_control_unit;

    logic       clk;
    logic       rst;
    logic [7:0] instruction;
    logic       zero;
    logic [3:0] alu_opcode;
    logic [3:0] load_r;
    logic       load_pc;
    logic       inc_pc;
    logic [2:0] sel_bus_1;
    logic [1:0] sel_bus_2;
    logic       load_ir;
    logic       load_add_r;
    logic       load_reg_y;
    logic       load_reg_z;
    logic       write;
    logic [3:0] state;

    int chk_cnt;
    int pass_cnt;

    // Strobe bundle layout: {load_r[3:0], load_pc, inc_pc, load_ir,
    //                        load_add_r, load_reg_y, load_reg_z, write}
    localparam logic [10:0] B_NONE = 11'd0;
    localparam logic [10:0] B_W    = 11'd1;
    localparam logic [10:0] B_Z    = 11'd2;
    localparam logic [10:0] B_Y    = 11'd4;
    localparam logic [10:0] B_AR   = 11'd8;
    localparam logic [10:0] B_IR   = 11'd16;
    localparam logic [10:0] B_INC  = 11'd32;
    localparam logic [10:0] B_PC   = 11'd64;
    localparam logic [10:0] B_R0   = 11'b0001_0000000;
    localparam logic [10:0] B_R1   = 11'b0010_0000000;
    localparam logic [10:0] B_R2   = 11'b0100_0000000;
    localparam logic [10:0] B_R3   = 11'b1000_0000000;

    control_unit #(.WORD(8), .NREG(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .zero        (zero),
        .alu_opcode  (alu_opcode),
        .load_r      (load_r),
        .load_pc     (load_pc),
        .inc_pc      (inc_pc),
        .sel_bus_1   (sel_bus_1),
        .sel_bus_2   (sel_bus_2),
        .load_ir     (load_ir),
        .load_add_r  (load_add_r),
        .load_reg_y  (load_reg_y),
        .load_reg_z  (load_reg_z),
        .write       (write),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Compare state and the whole output set (selects + strobes) in one cycle.
    task automatic expect_cycle(input string tag, input logic [3:0] exp_state,
                                input logic [2:0] exp_s1, input logic [1:0] exp_s2,
                                input logic [10:0] exp_strb);
        check({tag, ".state"}, 32'(state), 32'(exp_state));
        check({tag, ".outs"},
              32'({sel_bus_1, sel_bus_2, load_r, load_pc, inc_pc, load_ir,
                   load_add_r, load_reg_y, load_reg_z, write}),
              32'({exp_s1, exp_s2, exp_strb}));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Common fetch: called while the DUT sits in FET1; leaves it in DEC.
    task automatic fetch(input string tag);
        expect_cycle({tag, ".fet1"}, 4'd1, 3'd4, 2'd1, B_AR);
        tick();
        expect_cycle({tag, ".fet2"}, 4'd2, 3'd0, 2'd2, B_IR | B_INC);
        tick();
    endtask

    initial begin
        chk_cnt     = 0;
        pass_cnt    = 0;
        rst         = 1'b0;
        zero        = 1'b0;
        instruction = 8'h16;

        // Reset state and release timing.
        tick();
        tick();
        expect_cycle("reset", 4'd0, 3'd0, 2'd0, B_NONE);
        rst = 1'b1;
        #1;
        expect_cycle("rel.idle0", 4'd0, 3'd0, 2'd0, B_NONE);
        tick();
        expect_cycle("rel.idle1", 4'd0, 3'd0, 2'd0, B_NONE);
        tick();

        // ADD R1,R2 (0x16): src=1, dest=2.
        fetch("add");
        expect_cycle("add.dec", 4'd3, 3'd1, 2'd1, B_Y);
        check("add.op_dec", 32'(alu_opcode), 32'd1);
        tick();
        expect_cycle("add.ex1", 4'd4, 3'd2, 2'd0, B_R2 | B_Z);
        check("add.op_ex1", 32'(alu_opcode), 32'd1);
        tick();

        // SUB R2,R3 (0x2B): src=2, dest=3.
        instruction = 8'h2B;
        fetch("sub");
        expect_cycle("sub.dec", 4'd3, 3'd2, 2'd1, B_Y);
        tick();
        expect_cycle("sub.ex1", 4'd4, 3'd3, 2'd0, B_R3 | B_Z);
        tick();

        // RD into R3 (0x53).
        instruction = 8'h53;
        fetch("rd");
        expect_cycle("rd.dec", 4'd3, 3'd4, 2'd1, B_AR);
        tick();
        expect_cycle("rd.rd1", 4'd5, 3'd0, 2'd2, B_AR | B_INC);
        tick();
        expect_cycle("rd.rd2", 4'd6, 3'd0, 2'd2, B_R3);
        tick();

        // WR from R1 (0x67): src=1.
        instruction = 8'h67;
        fetch("wr");
        expect_cycle("wr.dec", 4'd3, 3'd4, 2'd1, B_AR);
        tick();
        expect_cycle("wr.wr1", 4'd7, 3'd0, 2'd2, B_AR | B_INC);
        tick();
        expect_cycle("wr.wr2", 4'd8, 3'd1, 2'd0, B_W);
        tick();

        // WR again, aborted by reset in WR2.
        fetch("wra");
        tick();
        tick();
        expect_cycle("wra.wr2", 4'd8, 3'd1, 2'd0, B_W);
        #2;
        rst = 1'b0;
        #1;
        expect_cycle("wra.abort", 4'd0, 3'd0, 2'd0, B_NONE);
        tick();
        rst = 1'b1;
        #1;
        expect_cycle("wra.rel0", 4'd0, 3'd0, 2'd0, B_NONE);
        tick();
        expect_cycle("wra.rel1", 4'd0, 3'd0, 2'd0, B_NONE);
        tick();

        // BRZ not taken (0x80, zero=0).
        instruction = 8'h80;
        zero        = 1'b0;
        fetch("brz0");
        expect_cycle("brz0.dec", 4'd3, 3'd0, 2'd0, B_INC);
        tick();

        // BRZ taken (zero=1).
        zero = 1'b1;
        fetch("brz1");
        expect_cycle("brz1.dec", 4'd3, 3'd4, 2'd1, B_AR);
        tick();
        expect_cycle("brz1.br1", 4'd9, 3'd0, 2'd2, B_AR);
        tick();
        expect_cycle("brz1.br2", 4'd10, 3'd0, 2'd2, B_PC);
        tick();
        zero = 1'b0;

        // Unconditional BR (0x70).
        instruction = 8'h70;
        fetch("br");
        expect_cycle("br.dec", 4'd3, 3'd4, 2'd1, B_AR);
        tick();
        expect_cycle("br.br1", 4'd9, 3'd0, 2'd2, B_AR);
        tick();
        expect_cycle("br.br2", 4'd10, 3'd0, 2'd2, B_PC);
        tick();

        // NOT R0 -> R1 (0x41).
        instruction = 8'h41;
        fetch("not");
        expect_cycle("not.dec", 4'd3, 3'd0, 2'd0, B_R1 | B_Z);
        tick();

        // NOP.
        instruction = 8'h00;
        fetch("nop");
        expect_cycle("nop.dec", 4'd3, 3'd0, 2'd0, B_NONE);
        tick();

        // AND R3,R0 (0x3C): src=3, dest=0.
        instruction = 8'h3C;
        fetch("and");
        expect_cycle("and.dec", 4'd3, 3'd3, 2'd1, B_Y);
        tick();
        expect_cycle("and.ex1", 4'd4, 3'd0, 2'd0, B_R0 | B_Z);
        tick();

        // Illegal 0xF0 halts until reset.
        instruction = 8'hF0;
        fetch("ill");
        expect_cycle("ill.dec", 4'd3, 3'd0, 2'd0, B_NONE);
        tick();
        instruction = 8'h16;
        for (int i = 0; i < 20; i++) begin
            expect_cycle($sformatf("halt%0d", i), 4'd11, 3'd0, 2'd0, B_NONE);
            tick();
        end
        rst = 1'b0;
        #1;
        expect_cycle("halt.rst", 4'd0, 3'd0, 2'd0, B_NONE);
        tick();
        rst = 1'b1;
        tick();
        tick();
        expect_cycle("halt.recover", 4'd1, 3'd4, 2'd1, B_AR);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Sequencer for the RISC stored-program machine: the producer side of the ALU interface.
- Fetches and decodes 8-bit instructions, then drives the ALU opcode, bus multiplexer selects and register load strobes.
- Consumes the registered zero flag to resolve BRZ.
- Sits between the instruction register and the datapath: processor = control_unit + datapath + memory.

Parameters:
- WORD, 8, instruction/data word width (opcode field is always [WORD-1:WORD-4]).
- NREG, 4, number of general registers R0..R3 (src = instr[3:2], dest = instr[1:0]).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- instruction  input  8  current IR contents
- zero  input  1  registered ALU zero flag (Reg_Z_flag)
- alu_opcode  output  4  = instruction[7:4], combinational, to ALU opcode
- load_r  output  4  one-hot load strobe for R0..R3
- load_pc  output  1  load PC from bus_2
- inc_pc  output  1  PC <= PC+1
- sel_bus_1  output  3  0..3 = R0..R3, 4 = PC
- sel_bus_2  output  2  0 = ALU_out, 1 = bus_1, 2 = mem_word
- load_ir, load_add_r, load_reg_y, load_reg_z  output  1 each  datapath register strobes
- write  output  1  memory write strobe
- state  output  4  current state, debug/verification

Behaviour:
- Opcodes: NOP 0, ADD 1, SUB 2, AND 3, NOT 4, RD 5, WR 6, BR 7, BRZ 8. Codes 9-15 are illegal.
- States: IDLE 0, FET1 1, FET2 2, DEC 3, EX1 4, RD1 5, RD2 6, WR1 7, WR2 8, BR1 9, BR2 10, HALT 11.
- Reset (rst=0, async): state = IDLE. All strobes 0, sel_bus_1 = 0, sel_bus_2 = 0.
- Strobe outputs are combinational from state + instruction. Each is 0 unless listed for the current state.
- IDLE: no strobes; next FET1.
- FET1: sel_bus_1=4, sel_bus_2=1, load_add_r; next FET2.
- FET2: sel_bus_2=2, load_ir, inc_pc; next DEC.
- DEC:
  - NOP: next FET1.
  - ADD/SUB/AND: sel_bus_1=src, sel_bus_2=1, load_reg_y; next EX1.
  - NOT: sel_bus_1=src, sel_bus_2=0, load_reg_z, load_r[dest]; next FET1.
  - RD/WR/BR: sel_bus_1=4, sel_bus_2=1, load_add_r; next RD1/WR1/BR1.
  - BRZ, zero=1: as BR; next BR1.
  - BRZ, zero=0: inc_pc (skip operand word); next FET1.
  - Illegal: next HALT.
- EX1: sel_bus_1=dest, sel_bus_2=0, load_reg_z, load_r[dest]; next FET1. ALU data_2 = Reg_Y (src), data_1 = bus_1 (dest), so SUB yields src-dest.
- RD1: sel_bus_2=2, load_add_r, inc_pc; next RD2.
- RD2: sel_bus_2=2, load_r[dest]; next FET1.
- WR1: sel_bus_2=2, load_add_r, inc_pc; next WR2.
- WR2: sel_bus_1=src, write; next FET1.
- BR1: sel_bus_2=2, load_add_r; next BR2.
- BR2: sel_bus_2=2, load_pc; next FET1.
- HALT: all strobes 0; held until rst asserted.
- Cycle counts from FET1 to next FET1:
  - NOP 3, NOT 3, BRZ not-taken 3
  - ADD/SUB/AND 4
  - RD, WR, BR, BRZ taken 5
- load_r is never multi-hot. load_pc and inc_pc are never both 1.
- Unused state encodings (12-15) go to HALT.
- rst asserted mid-instruction aborts it immediately: no strobe persists after the asynchronous edge.
- First FET1 occurs on the 2nd rising edge after rst deasserts.

Test Plan:
- Reset: rst=0 during WR2 -> state=0 and write=0 immediately; after release, IDLE, FET1, FET2 on successive edges.
- ADD R1,R2 (instruction 0x16):
  - DEC: sel_bus_1=1, load_reg_y.
  - EX1: sel_bus_1=2, sel_bus_2=0, load_r=4'b0100, load_reg_z.
  - alu_opcode=1 throughout.
  - FET1 reached after 4 cycles.
- RD into R3 (0x53): RD1 inc_pc=1; RD2 sel_bus_2=2, load_r=4'b1000; 5 cycles total.
- BRZ (0x80):
  - zero=0: DEC inc_pc=1, next FET1.
  - zero=1: BR1 then BR2 with load_pc=1.
- NOT R0->R1 (0x41): single DEC cycle shows load_reg_z=1, load_r=4'b0010, sel_bus_2=0; next FET1.
- Illegal 0xF0: DEC -> HALT. State stays 11 with all strobes 0 for 20 cycles; recovers only via rst.
